// File: rtl/ntt_pkg.sv
// Shared constants, state type and butterfly schedule for the 8-point NTT sequencer.
// Latency: n/a (types, constants and a pure combinational lookup function).
// Backpressure: n/a.
// Contents: DW/N defaults, state_t, twiddle-select codes, bfly_t entry and bfly_lut(c).
package ntt_pkg;

  localparam int DW    = 8;
  localparam int N     = 8;
  localparam int NBFLY = 12;  // 3 stages x 4 butterflies

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] TW_SEL_0 = 2'd0;
  localparam logic [1:0] TW_SEL_1 = 2'd1;
  localparam logic [1:0] TW_SEL_2 = 2'd2;
  localparam logic [1:0] TW_SEL_3 = 2'd3;

  // One schedule entry: register-file indices of the pair and which twiddle to use.
  typedef struct packed {
    logic [2:0] lo;
    logic [2:0] hi;
    logic [1:0] tw;
  } bfly_t;

  // Butterfly c -> (lo, hi, twiddle). Stage s = c/4, butterfly j = c%4.
  // Stage 0 pairs neighbours, stage 1 pairs at distance 2, stage 2 at distance 4.
  function automatic bfly_t bfly_lut(input logic [3:0] c);
    bfly_t      e;
    logic [1:0] j;
    j = c[1:0];
    e = '0;
    case (c[3:2])
      2'd0: begin
        e.lo = {j, 1'b0};
        e.hi = {j, 1'b1};
        e.tw = TW_SEL_0;
      end
      2'd1: begin
        e.lo = {j[1], 1'b0, j[0]};
        e.hi = {j[1], 1'b1, j[0]};
        e.tw = j[0] ? TW_SEL_2 : TW_SEL_0;
      end
      2'd2: begin
        e.lo = {1'b0, j};
        e.hi = {1'b1, j};
        case (j)
          2'd0:    e.tw = TW_SEL_0;
          2'd1:    e.tw = TW_SEL_1;
          2'd2:    e.tw = TW_SEL_2;
          default: e.tw = TW_SEL_3;
        endcase
      end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mod_butterfly.sv
// Combinational modular butterfly: lo = (a + b*w) mod m, hi = (a - b*w) mod m.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers results.
// Ports: a, b, w, m in (DW each); lo, hi out (DW each).
module mod_butterfly #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] m,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi
);

  // Product needs 2*DW bits and the sum one more; reduce only at the very end.
  localparam int PW = 2 * DW + 1;

  logic [DW-1:0] m_safe;
  logic [DW-1:0] w_red;
  logic [DW-1:0] w_neg;
  logic [PW-1:0] m_ext;
  logic [PW-1:0] sum_lo;
  logic [PW-1:0] sum_hi;

  always_comb begin
    // m == 0 would be a divide by zero; the sequencer never uses results when m < 2.
    m_safe = (m == '0) ? DW'(1) : m;
    w_red  = w % m_safe;
    // -w mod m expressed as a non-negative value in 1..m, keeping the math unsigned.
    w_neg  = m_safe - w_red;
    m_ext  = PW'(m_safe);
    sum_lo = PW'(a) + PW'(b) * PW'(w);
    sum_hi = PW'(a) + PW'(b) * PW'(w_neg);
    lo     = DW'(sum_lo % m_ext);
    hi     = DW'(sum_hi % m_ext);
  end

endmodule

// File: rtl/ntt8_butterfly_sequencer.sv
// Iterative 8-point NTT: load 8 coefficients, run 12 in-place butterflies, stream 8 results.
// Latency: beat-7 accept at edge E -> first m_valid at E+13; one butterfly per cycle.
// Backpressure: s_ready low outside IDLE/LOAD; m_data/m_last held while m_valid && !m_ready.
// Ports: clk, rst_n; s_valid/s_ready/s_data, cfg_mod, cfg_omegas in; m_valid/m_ready/m_data/m_last, busy, err.
module ntt8_butterfly_sequencer #(
  parameter int DW = ntt_pkg::DW,
  parameter int N  = ntt_pkg::N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic [DW-1:0]   cfg_mod,
  input  logic [4*DW-1:0] cfg_omegas,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic            busy,
  output logic            err
);

  import ntt_pkg::state_t, ntt_pkg::bfly_t, ntt_pkg::bfly_lut, ntt_pkg::NBFLY;
  import ntt_pkg::ST_IDLE, ntt_pkg::ST_LOAD, ntt_pkg::ST_COMPUTE, ntt_pkg::ST_DRAIN;

  localparam int         AW        = $clog2(N);
  localparam logic [3:0] LAST_BEAT = 4'(N - 1);
  localparam logic [3:0] LAST_BFLY = 4'(NBFLY - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;       // beat index in LOAD/DRAIN, butterfly index in COMPUTE
  logic [DW-1:0]   mod_q, mod_d;
  logic [4*DW-1:0] omg_q, omg_d;
  logic            err_q, err_d;
  logic            s_ready_q, s_ready_d;
  logic            busy_q, busy_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [DW-1:0]   rf_q [N];
  logic [DW-1:0]   rf_d [N];

  bfly_t           bf;
  logic [DW-1:0]   bf_a, bf_b, bf_w, bf_lo, bf_hi;
  logic [3:0]      cnt_inc;
  logic            s_fire;

  assign s_fire  = s_valid && s_ready_q;
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    bf   = bfly_lut(cnt_q);
    bf_a = rf_q[bf.lo];
    bf_b = rf_q[bf.hi];
    bf_w = omg_q[32'(bf.tw) * DW +: DW];
  end

  mod_butterfly #(.DW(DW)) u_bfly (
    .a  (bf_a),
    .b  (bf_b),
    .w  (bf_w),
    .m  (mod_q),
    .lo (bf_lo),
    .hi (bf_hi)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mod_d     = mod_q;
    omg_d     = omg_q;
    err_d     = err_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    rf_d      = rf_q;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (s_fire) begin
          rf_d[cnt_q[AW-1:0]] = s_data;
          if (state_q == ST_IDLE) begin
            mod_d = cfg_mod;
            omg_d = cfg_omegas;
            err_d = (cfg_mod < DW'(2));
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            // A degenerate modulus has no meaningful transform: drain zeros instead.
            state_d = err_q ? ST_DRAIN : ST_COMPUTE;
          end else begin
            cnt_d   = cnt_inc;
            state_d = ST_LOAD;
          end
        end
      end
      ST_COMPUTE: begin
        rf_d[bf.lo] = bf_lo;
        rf_d[bf.hi] = bf_hi;
        if (cnt_q == LAST_BFLY) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DRAIN: begin
        // First DRAIN cycle only primes the output register from the register file.
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = err_q ? '0 : rf_q[cnt_q[AW-1:0]];
          m_last_d  = (cnt_q == LAST_BEAT);
        end else if (m_ready) begin
          if (m_last_q) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end else begin
            cnt_d    = cnt_inc;
            m_data_d = err_q ? '0 : rf_q[cnt_inc[AW-1:0]];
            m_last_d = (cnt_inc == LAST_BEAT);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mod_q     <= '0;
      omg_q     <= '0;
      err_q     <= 1'b0;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mod_q     <= mod_d;
      omg_q     <= omg_d;
      err_q     <= err_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  // Register file is deliberately not reset; every transform overwrites all entries.
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_ntt8_butterfly_sequencer.sv
// Directed bench for ntt8_butterfly_sequencer with hand-computed transforms.
// Latency: checks first m_valid 13 cycles after the beat-7 accept.
// Backpressure: exercises s_valid gaps and m_ready stalls with hold checks.
module tb_ntt8_butterfly_sequencer;

  localparam int DW = 8;
  localparam logic [31:0] OMG_17 = 32'h08040201;  // w3=8, w2=4, w1=2, w0=1

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic [DW-1:0]   cfg_mod;
  logic [4*DW-1:0] cfg_omegas;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic            busy;
  logic            err;

  int  n_chk  = 0;
  int  n_fail = 0;
  time t7;

  logic [DW-1:0] vin  [8];
  logic [DW-1:0] vexp [8];

  always #5 clk = ~clk;

  ntt8_butterfly_sequencer #(.DW(DW), .N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .cfg_mod    (cfg_mod),
    .cfg_omegas (cfg_omegas),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Feeds vin[0..7]; returns 1 time unit after the beat-7 accept edge (t7 = that edge).
  task automatic send(input logic [DW-1:0] mod, input logic [31:0] omg, input bit gaps);
    int w;
    cfg_mod    = mod;
    cfg_omegas = omg;
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = vin[k];
      w = 0;
      while (!s_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!s_ready) begin
        check_eq("s_ready_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        // Config must have been captured on beat 0; scramble it afterwards.
        cfg_mod    = 8'hEE;
        cfg_omegas = $urandom;
      end
      if (k == 7) begin
        t7      = $time - 1;
        s_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Collects 8 beats and compares with vexp; optional m_ready stalls.
  task automatic recv(input bit bp, input bit chk_lat);
    int            w;
    logic [DW-1:0] held;
    for (int i = 0; i < 8; i++) begin
      w = 0;
      while (!m_valid && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!m_valid) begin
        check_eq("m_valid_timeout", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        return;
      end
      if (i == 0 && chk_lat)
        check_eq("first_valid_latency", 32'(($time - 5 - t7) / 10), 32'd13);
      if (bp) begin
        while ($urandom_range(0, 2) == 0) begin
          m_ready = 1'b0;
          held    = m_data;
          @(negedge clk);
          check_eq("hold_data", 32'(m_data), 32'(held));
          check_eq("hold_valid", 32'(m_valid), 32'd1);
        end
      end
      m_ready = 1'b1;
      check_eq($sformatf("m_data[%0d]", i), 32'(m_data), 32'(vexp[i]));
      check_eq($sformatf("m_last[%0d]", i), 32'(m_last), 32'(i == 7));
      check_eq("s_ready_drain", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    check_eq("s_ready_idle", 32'(s_ready), 32'd1);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("m_valid_idle", 32'(m_valid), 32'd0);
  endtask

  task automatic set_ones();
    for (int i = 0; i < 8; i++) begin
      vin[i]  = 8'd1;
      vexp[i] = (i == 0) ? 8'd8 : 8'd0;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    cfg_mod    = '0;
    cfg_omegas = '0;
    m_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_m_last", 32'(m_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All ones, M=17: only DC term survives; latency measured.
    set_ones();
    send(8'd17, OMG_17, 1'b0);
    check_eq("s_ready_compute", 32'(s_ready), 32'd0);
    check_eq("busy_compute", 32'(busy), 32'd1);
    recv(1'b0, 1'b1);

    // Impulse -> flat spectrum.
    vin  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vexp = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    send(8'd17, OMG_17, 1'b0);
    recv(1'b0, 1'b0);

    // Shifted impulse -> alternating 1, -1.
    vin  = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vexp = '{8'd1, 8'd16, 8'd1, 8'd16, 8'd1, 8'd16, 8'd1, 8'd16};
    send(8'd17, OMG_17, 1'b0);
    recv(1'b0, 1'b0);

    // Wide product: 250*250 must not be truncated to 8 bits.
    vin  = '{8'd0, 8'd250, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vexp = '{8'd250, 8'd1, 8'd250, 8'd1, 8'd250, 8'd1, 8'd250, 8'd1};
    send(8'd251, 32'h01010101, 1'b0);
    recv(1'b0, 1'b0);

    // Dense input under input gaps and output stalls; exercises every twiddle.
    vin  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    vexp = '{8'd2, 8'd2, 8'd14, 8'd10, 8'd1, 8'd5, 8'd12, 8'd13};
    send(8'd17, OMG_17, 1'b1);
    recv(1'b1, 1'b0);

    // Same shifted impulse under backpressure.
    vin  = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vexp = '{8'd1, 8'd16, 8'd1, 8'd16, 8'd1, 8'd16, 8'd1, 8'd16};
    send(8'd17, OMG_17, 1'b1);
    recv(1'b1, 1'b0);

    // Reset during compute cycle c=5 abandons the transform.
    set_ones();
    send(8'd17, OMG_17, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_m_valid", 32'(m_valid), 32'd0);
    check_eq("midrst_s_ready", 32'(s_ready), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_m_data", 32'(m_data), 32'd0);
    check_eq("midrst_m_last", 32'(m_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("postrst_m_valid", 32'(m_valid), 32'd0);
    send(8'd17, OMG_17, 1'b0);
    recv(1'b0, 1'b0);

    // Degenerate modulus: error flag and eight zeros.
    set_ones();
    for (int i = 0; i < 8; i++) vexp[i] = 8'd0;
    send(8'd1, OMG_17, 1'b0);
    check_eq("err_set", 32'(err), 32'd1);
    recv(1'b0, 1'b0);
    check_eq("err_sticky", 32'(err), 32'd1);

    // Next valid transform clears the flag.
    set_ones();
    send(8'd17, OMG_17, 1'b0);
    check_eq("err_clear", 32'(err), 32'd0);
    recv(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
